// File: rtl/resp_chk16.sv
// resp_chk16: sequential response checker for 16-bit gate benches.
// Consumes observed/expected pairs over valid/ready, counts vectors and
// mismatches, latches the first failing vector, and reports pass/fail
// once the beat flagged 'last' has been accepted.
//
// Optional feature macro: RESP_CHK16_SIG_EN
//   defined   -> 'sig' port and 16-bit response signature register exist
//   undefined -> no 'sig' port, no signature register
//
// Ports:
//   clk            in   rising-edge clock
//   rst_n          in   asynchronous active-low reset
//   start          in   one-cycle pulse: clear results, begin a run
//   in_valid       in   observed/expected pair present
//   in_ready       out  pair accepted this cycle (RUN and no start)
//   y              in   observed result [15:0]
//   exp            in   expected result [15:0]
//   last           in   current pair is the final vector of the run
//   done           out  run complete, results stable
//   pass           out  done with zero mismatches
//   vec_cnt        out  vectors accepted (saturating) [CNT_W-1:0]
//   err_cnt        out  mismatching vectors (saturating) [CNT_W-1:0]
//   first_err_idx  out  0-based index of first mismatch [CNT_W-1:0]
//   first_err_diff out  y ^ exp of first mismatch [15:0]
//   sig            out  response signature [15:0] (RESP_CHK16_SIG_EN only)

module resp_chk16 #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      y,
    input  logic [15:0]      exp,
    input  logic             last,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] vec_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [15:0]      first_err_diff
`ifdef RESP_CHK16_SIG_EN
    ,
    output logic [15:0]      sig
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t            r_state;
    state_t            w_state_nxt;

    logic [CNT_W-1:0]  r_vec_cnt;
    logic [CNT_W-1:0]  r_err_cnt;
    logic [CNT_W-1:0]  r_first_idx;
    logic [15:0]       r_first_diff;
    logic              r_done;
    logic              r_pass;

    logic              w_ready;
    logic              w_accept;
    logic [15:0]       w_diff;
    logic              w_mis;
    logic              w_first;

    // A beat offered alongside start is dropped: start wins the cycle.
    assign w_ready  = (r_state == S_RUN) && !start;
    assign w_accept = in_valid && w_ready;
    assign w_diff   = y ^ exp;
    assign w_mis    = (w_diff != 16'h0000);
    // err_cnt saturates but never wraps to 0, so zero means no mismatch yet.
    assign w_first  = w_mis && (r_err_cnt == CNT_ZERO);

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_nxt = r_state;
        if (start) begin
            w_state_nxt = S_RUN;
        end else begin
            unique case (r_state)
                S_IDLE: w_state_nxt = S_IDLE;
                S_RUN: begin
                    if (w_accept && last) begin
                        w_state_nxt = S_DONE;
                    end
                end
                S_DONE: w_state_nxt = S_DONE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // ---------------- counters and first-error capture ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vec_cnt    <= CNT_ZERO;
            r_err_cnt    <= CNT_ZERO;
            r_first_idx  <= CNT_ZERO;
            r_first_diff <= 16'h0000;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
        end else if (start) begin
            r_vec_cnt    <= CNT_ZERO;
            r_err_cnt    <= CNT_ZERO;
            r_first_idx  <= CNT_ZERO;
            r_first_diff <= 16'h0000;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
        end else if (w_accept) begin
            if (r_vec_cnt != CNT_MAX) begin
                r_vec_cnt <= r_vec_cnt + CNT_ONE;
            end
            if (w_mis && (r_err_cnt != CNT_MAX)) begin
                r_err_cnt <= r_err_cnt + CNT_ONE;
            end
            if (w_first) begin
                r_first_idx  <= r_vec_cnt;
                r_first_diff <= w_diff;
            end
            if (last) begin
                r_done <= 1'b1;
                // The final beat itself counts towards pass/fail.
                r_pass <= (r_err_cnt == CNT_ZERO) && !w_mis;
            end
        end
    end

`ifdef RESP_CHK16_SIG_EN
    logic [15:0] r_sig;
    logic [15:0] w_sig_nxt;

    // Shift-left LFSR step (taps 16'h1009) folded with the observed word.
    assign w_sig_nxt = {r_sig[14:0], 1'b0}
                     ^ (r_sig[15] ? 16'h1009 : 16'h0000)
                     ^ y;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sig <= 16'hFFFF;
        end else if (start) begin
            r_sig <= 16'hFFFF;
        end else if (w_accept) begin
            r_sig <= w_sig_nxt;
        end
    end

    assign sig = r_sig;
`endif

    // ---------------- outputs ----------------
    assign in_ready       = w_ready;
    assign done           = r_done;
    assign pass           = r_pass;
    assign vec_cnt        = r_vec_cnt;
    assign err_cnt        = r_err_cnt;
    assign first_err_idx  = r_first_idx;
    assign first_err_diff = r_first_diff;

endmodule

// File: doc/resp_chk16.md
# resp_chk16

Sequential response checker for 16-bit combinational gate benches. It consumes a stream of observed 16-bit results, each paired with its expected value, over a valid/ready handshake. It counts vectors and mismatches and latches the first failing vector. It reports pass/fail when the final vector is flagged. It sits on the read side of a vector stream, opposite the stimulus driver, with the gate under test (e.g. an OR16 stage) between them.

## Interface
Parameters:
- `CNT_W`, 8, width of vector and error counters; both saturate at 2^CNT_W-1.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  sole clock; rising-edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  one-cycle pulse: clear results and begin a run.
- `in_valid`  in  1  observed/expected pair present.
- `in_ready`  out  1  checker accepts a pair this cycle.
- `y`  in  16  observed DUT result.
- `exp`  in  16  expected result.
- `last`  in  1  qualifies the current pair as the final vector of the run.
- `done`  out  1  run complete; results stable.
- `pass`  out  1  done with zero mismatches.
- `vec_cnt`  out  CNT_W  vectors accepted.
- `err_cnt`  out  CNT_W  mismatching vectors.
- `first_err_idx`  out  CNT_W  index (0-based) of the first mismatch.
- `first_err_diff`  out  16  `y ^ exp` of the first mismatch.
- `sig`  out  16  response signature (only with SIG_EN).

## Operation
- States: IDLE, RUN, DONE; reset enters IDLE.
- IDLE -> RUN on `start`. DONE -> RUN on `start`. RUN -> RUN on `start` (restart). RUN -> DONE on an accepted beat with `last`=1.
- `start` in any state clears `vec_cnt`, `err_cnt`, `first_err_idx`, `first_err_diff`, `done`, `pass`, and seeds `sig`=16'hFFFF.
- `in_ready` = (state==RUN) && !`start`. A beat offered in the same cycle as `start` is not accepted.
- Accept = `in_valid` && `in_ready`. On accept:
  - `vec_cnt` increments, saturating.
  - If `y`!=`exp`, `err_cnt` increments, saturating.
  - On the first mismatch only (`err_cnt`==0 before the update), capture `first_err_idx`=`vec_cnt` (pre-increment value) and `first_err_diff`=`y^exp`.
- Saturation does not block acceptance. A run longer than 2^CNT_W-1 vectors holds `vec_cnt` at max. `first_err_idx` captures the saturated value.
- `pass` = no mismatch in the run, including the final beat. It is meaningful only while `done`=1 and is 0 otherwise.
- In IDLE and DONE, `in_valid` is ignored; no counter changes.

## Timing
- Reset values: `in_ready`=0, `done`=0, `pass`=0, all counters and capture fields 0, `sig`=16'hFFFF.
- Reset asserted mid-run aborts immediately and asynchronously to the reset values. Partial results are lost.
- `in_ready` is combinational from the state register and `start`. All other outputs are registered.
- Counters and captures reflect a beat on the clock edge that accepts it, i.e. visible the next cycle.
- `done` and `pass` assert one cycle after the edge accepting the `last` beat. They hold until `start` or reset.
- Throughput: one pair per cycle while `in_valid` is held high in RUN.
- `last` is sampled only on accepted beats.

## Configuration
- `RESP_CHK16_SIG_EN` defined:
  - `sig` port exists.
  - On every accepted beat, `sig` <= ({`sig`[14:0],1'b0} ^ (`sig`[15] ? 16'h1009 : 16'h0000)) ^ `y`.
  - Seed is 16'hFFFF on reset and on `start`.
  - `sig` holds its value in IDLE and DONE.
- Undefined: the `sig` port and the signature register are absent. All other behaviour is identical.

## Test plan
- Reset, then `start`, then 4 matching beats of OR16 results (y=exp=0,1,1,1), `last` on the 4th -> next cycle `done`=1, `pass`=1, `vec_cnt`=4, `err_cnt`=0.
- Run of 2 beats: y=16'h7FFF/exp=16'h7FFF, then y=16'h7FFE/exp=16'h7FFF with `last` -> `pass`=0, `err_cnt`=1, `first_err_idx`=1, `first_err_diff`=16'h0001.
- Toggle `in_valid` with gaps. Assert `start` while `in_valid`=1 mid-run -> `in_ready`=0 that cycle, counters cleared, subsequent beats counted from 0.
- With CNT_W=8, send 300 mismatching beats -> `vec_cnt`=255, `err_cnt`=255, `first_err_idx`=0.
- Drop `rst_n` with no clock edge mid-run after 3 beats -> all outputs return to reset values immediately. Beats offered afterward are not accepted (`in_ready`=0) until `start`.
- With `RESP_CHK16_SIG_EN`: `start`, then one beat y=16'h0000 -> `sig`=16'hEFF7. `sig` holds at 16'hEFF7 after `done`.
